keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 hex matrix keypad by driving one column low at a time and sampling the rows. Debounces the result over whole scans and emits one code per press. Shifts each accepted digit into a 16-bit entry register that feeds the 4-digit seven-segment display path as its 16-bit value. This is the input-side counterpart of the display multiplexer: it drives column selects and reads back, where the display drives digit selects and writes out.

## Interface
- SCAN_DIV, 2500: clock cycles each column is driven; ≥2.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press or a release; 1..255.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- row_in  in  4  keypad rows, active-low (externally pulled up).
- clear  in  1  synchronous clear of entry.
- col_sel  out  4  keypad columns, active-low one-hot; col_sel[i] low drives column i.
- key_code  out  4  last accepted key (hex value).
- key_valid  out  1  one-cycle pulse per accepted press.
- key_held  out  1  high from acceptance until release is debounced.
- entry  out  16  last four accepted digits; newest in [3:0].

## Operation
- Divider: div counts 0..SCAN_DIV-1. col_idx (2 bits) increments on div wrap, 3→0 wrap-around. col_sel = ~(4'b0001 << col_idx).
- Sampling: on div==SCAN_DIV-1, row_in is sampled for column col_idx. This gives settle time after the column switch.
- Scan result is accumulated over col_idx 0..3 and classified at the col 3 sample as NONE, SINGLE(code), or MULTI. MULTI means two or more low rows total, across any columns.
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM, evaluated once per scan end; cnt is 8 bits:
  - IDLE:
    - SINGLE(k) → cand=k, cnt=1, DEBOUNCE.
    - NONE or MULTI → stay.
  - DEBOUNCE:
    - SINGLE(cand) → cnt+1.
    - When cnt+1 == DEBOUNCE_SCANS: key_code=cand, key_valid pulse, entry={entry[11:0],cand}, PRESSED.
    - Any other result → IDLE.
    - If DEBOUNCE_SCANS==1, IDLE accepts directly on the first SINGLE.
  - PRESSED:
    - key_held=1.
    - NONE → cnt=1, RELEASE.
    - SINGLE or MULTI → stay. No auto-repeat; a different key while held is ignored.
  - RELEASE:
    - NONE → cnt+1; at DEBOUNCE_SCANS → IDLE, key_held=0.
    - SINGLE or MULTI → PRESSED, with no new pulse.
- clear=1 sets entry to 0. If key_valid fires in the same cycle, entry = {12'h000, cand}.
- Reset mid-operation discards any partial scan, candidate, and count.

## Timing
- Reset values:
  - col_sel=4'b1110, key_code=0, key_valid=0, key_held=0, entry=16'h0000.
  - div=0, col_idx=0, FSM=IDLE.
- Scan period is 4·SCAN_DIV cycles. The first scan end is at cycle 4·SCAN_DIV-1 after reset release.
- key_valid, key_code, entry and key_held update in the cycle after the scan-end sample that completes debounce.
- key_valid is high for exactly 1 cycle. key_code holds its value until the next acceptance.
- Minimum press-to-pulse latency is DEBOUNCE_SCANS full scans, +1 cycle.
- Release-to-key_held-low latency is DEBOUNCE_SCANS NONE scans, +1 cycle.
- All outputs are registered. There are no combinational paths from row_in to outputs.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3 (scan = 16 cycles).

1. Reset, then hold row1 low only while col 1 is driven, steadily → exactly one key_valid with key_code=5 and entry=16'h0005. key_held stays high through 50 scans with no further pulses. After release, key_held falls 3 scans + 1 cycle later.
2. Press 1, 2, 3, 4, A in turn, each held 5 scans and released 5 scans → five pulses; entry goes 0001, 0012, 0123, 1234, then 234A.
3. Bounce: key 9 present for 2 scans, absent for 1, present for 2 → no pulse, state returns to IDLE. Then hold 3 scans → one pulse with key_code=9.
4. Keys 1 and 4 held simultaneously for 10 scans → no pulse, key_held=0. Release 4 and keep 1 → pulse with key_code=1 after 3 scans.
5. Release glitch: hold key D to acceptance, release 2 scans, re-press 1 scan, release 3 scans → single pulse total; key_held falls only after the final 3 NONE scans.
6. Assert reset after 2 matching scans of key 7 → outputs at reset values, no pulse. Then assert clear together with an acceptance of key 7 while entry=16'h1234 → entry=16'h0007.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column strobe, row sampling,
// scan-level debounce and a 4-digit shift-in entry register.
module keypad_scanner #(
  parameter int SCAN_DIV       = 2500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_in,
  input  logic        clear,
  output logic [3:0]  col_sel,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entry
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [7:0] DB_N = 8'(DEBOUNCE_SCANS);
  // nibble {row, col} holds the legend of that key
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

  typedef enum logic [1:0] {
    IDLE, DEBOUNCE, PRESSED, RELEASE
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div;
  logic [1:0]    col_idx;
  logic [1:0]    acc_low;
  logic [3:0]    acc_code;
  logic [7:0]    cnt, cnt_n, cnt_inc;
  logic [3:0]    cand, cand_n;
  logic          sample, scan_end;
  logic [3:0]    low;
  logic [2:0]    col_cnt, tot_sum;
  logic [1:0]    row_hit, tot;
  logic [3:0]    cur_code;
  logic          res_none, res_single;
  logic          accept, release_done;

  assign sample   = (div == DIV_MAX);
  assign scan_end = sample && (col_idx == 2'd3);
  assign col_sel  = ~(4'b0001 << col_idx);
  assign low      = ~row_in;
  assign cnt_inc  = cnt + 8'd1;

  always_comb begin
    row_hit = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (low[r]) row_hit = 2'(r);
    end
  end

  // Two or more low rows anywhere in a scan saturate to MULTI
  always_comb begin
    col_cnt = {2'b0, low[0]} + {2'b0, low[1]}
            + {2'b0, low[2]} + {2'b0, low[3]};
    tot_sum = {1'b0, acc_low} + col_cnt;
    tot     = (tot_sum > 3'd1) ? 2'd2 : tot_sum[1:0];
    cur_code = (col_cnt == 3'd1)
             ? KEYMAP[{row_hit, col_idx, 2'b00} +: 4]
             : acc_code;
    res_none   = (tot == 2'd0);
    res_single = (tot == 2'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      col_idx  <= '0;
      acc_low  <= '0;
      acc_code <= '0;
    end else if (sample) begin
      div     <= '0;
      col_idx <= col_idx + 2'd1;
      if (col_idx == 2'd3) begin
        acc_low  <= '0;
        acc_code <= '0;
      end else begin
        acc_low  <= tot;
        acc_code <= cur_code;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cand_n       = cand;
    accept       = 1'b0;
    release_done = 1'b0;
    if (scan_end) begin
      unique case (state)
        IDLE: begin
          if (res_single) begin
            cand_n = cur_code;
            if (DB_N == 8'd1) begin
              accept  = 1'b1;
              state_n = PRESSED;
            end else begin
              cnt_n   = 8'd1;
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (res_single && cur_code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_N) begin
              accept  = 1'b1;
              state_n = PRESSED;
            end
          end else begin
            state_n = IDLE;
          end
        end
        PRESSED: begin
          if (res_none) begin
            cnt_n = 8'd1;
            if (DB_N == 8'd1) begin
              release_done = 1'b1;
              state_n      = IDLE;
            end else begin
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (res_none) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_N) begin
              release_done = 1'b1;
              state_n      = IDLE;
            end
          end else begin
            state_n = PRESSED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      entry     <= '0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= cand_n;
        key_held <= 1'b1;
        entry    <= clear ? {12'h000, cand_n}
                          : {entry[11:0], cand_n};
      end else begin
        if (release_done) key_held <= 1'b0;
        if (clear) entry <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with an ideal keypad
// matrix and a scan-level debounce model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_sel;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] entry;
  logic [15:0] pressed = 16'h0;

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;
  int p0;

  logic [3:0] kmap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .clear(clear),
    .col_sel(col_sel), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .entry(entry)
  );

  always #5 clk = ~clk;

  // ideal matrix: a row reads low if a pressed key sits on a driven column
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_in[r] = ~|(pressed[r*4 +: 4] & ~col_sel);
    end
  end

  function automatic logic [15:0] kbit(input logic [3:0] code);
    logic [15:0] m;
    m = 16'h0;
    for (int i = 0; i < 16; i++) begin
      if (kmap[i] == code) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model state
  bit          active = 0;
  int          m_phase, m_cnt, run, none_run;
  bit          m_held, nv;
  logic [3:0]  m_code, cand;
  logic        exp_valid, exp_held;
  logic [3:0]  exp_code, exp_cs;
  logic [15:0] exp_entry;
  logic [3:0]  one4 = 4'b0001;

  initial begin : cmp
    forever begin
      @(negedge clk);
      if (active) begin
        exp_cs = ~(one4 << (m_phase / SD));
        chk("col_sel", col_sel, exp_cs);
        chk("key_valid", key_valid, exp_valid);
        chk("key_code", key_code, exp_code);
        chk("key_held", key_held, exp_held);
        chk("entry", entry, exp_entry);
        if (key_valid === 1'b1) dut_pulses++;
      end
      if (reset) begin
        active = 1; m_phase = 0; m_cnt = 0; run = 0; none_run = 0;
        m_held = 0; m_code = 0; cand = 0;
        exp_valid = 0; exp_held = 0; exp_code = 0; exp_entry = 0;
      end else if (active) begin
        nv = 0;
        if (m_phase % SD == SD - 1) begin
          for (int r = 0; r < 4; r++) begin
            if (pressed[r*4 + m_phase/SD]) begin
              m_cnt++;
              m_code = kmap[r*4 + m_phase/SD];
            end
          end
        end
        if (m_phase == SCAN - 1) begin
          if (!m_held) begin
            if (m_cnt == 1) begin
              if (run == 0) begin cand = m_code; run = 1; end
              else if (m_code == cand) run++;
              else run = 0;
            end else run = 0;
            if (run == DB) begin
              nv = 1; m_held = 1; run = 0; none_run = 0;
            end
          end else if (m_cnt == 0) begin
            none_run++;
            if (none_run == DB) begin m_held = 0; none_run = 0; end
          end else none_run = 0;
          m_cnt = 0;
        end
        if (nv) begin
          exp_code  = cand;
          exp_entry = clear ? {12'h000, cand} : {exp_entry[11:0], cand};
        end else if (clear) exp_entry = 16'h0;
        exp_valid = nv;
        exp_held  = m_held;
        m_phase   = (m_phase + 1) % SCAN;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_scans(input int n);
    repeat (SCAN * n) @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [3:0] code, input int on, input int off);
    pressed = kbit(code);
    wait_scans(on);
    pressed = 16'h0;
    wait_scans(off);
  endtask

  logic [3:0]  seq2 [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA};
  logic [15:0] ent2 [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234, 16'h234A};

  initial begin : stim
    // 1: steady key 5
    do_reset();
    chk("rst_col_sel", col_sel, 4'b1110);
    chk("rst_entry", entry, 16'h0);
    chk("rst_held", key_held, 1'b0);
    p0 = dut_pulses;
    pressed = kbit(4'h5);
    wait_scans(DB);
    chk("t1_valid", key_valid, 1'b1);
    chk("t1_code", key_code, 4'h5);
    chk("t1_entry", entry, 16'h0005);
    wait_scans(50 - DB);
    chk("t1_pulses", dut_pulses - p0, 1);
    chk("t1_held", key_held, 1'b1);
    pressed = 16'h0;
    repeat (SCAN * DB - 1) @(posedge clk);
    #1 chk("t1_held_pre", key_held, 1'b1);
    @(posedge clk);
    #1 chk("t1_held_fall", key_held, 1'b0);
    wait_scans(2);

    // 2: digit sequence
    do_reset();
    p0 = dut_pulses;
    for (int i = 0; i < 5; i++) begin
      pressed = kbit(seq2[i]);
      wait_scans(5);
      chk("t2_entry", entry, ent2[i]);
      pressed = 16'h0;
      wait_scans(5);
    end
    chk("t2_pulses", dut_pulses - p0, 5);

    // 3: bounce
    p0 = dut_pulses;
    tap(4'h9, 2, 1);
    tap(4'h9, 2, 1);
    chk("t3_nopulse", dut_pulses - p0, 0);
    pressed = kbit(4'h9);
    wait_scans(DB);
    chk("t3_valid", key_valid, 1'b1);
    chk("t3_code", key_code, 4'h9);
    pressed = 16'h0;
    wait_scans(5);
    chk("t3_pulses", dut_pulses - p0, 1);

    // 4: two keys in one column
    p0 = dut_pulses;
    pressed = kbit(4'h1) | kbit(4'h4);
    wait_scans(10);
    chk("t4_nopulse", dut_pulses - p0, 0);
    chk("t4_held", key_held, 1'b0);
    pressed = kbit(4'h1);
    wait_scans(DB);
    chk("t4_valid", key_valid, 1'b1);
    chk("t4_code", key_code, 4'h1);
    pressed = 16'h0;
    wait_scans(5);

    // 5: release glitch
    p0 = dut_pulses;
    pressed = kbit(4'hD);
    wait_scans(DB);
    chk("t5_code", key_code, 4'hD);
    pressed = 16'h0;
    wait_scans(2);
    pressed = kbit(4'hD);
    wait_scans(1);
    pressed = 16'h0;
    repeat (SCAN * DB - 1) @(posedge clk);
    #1 chk("t5_held_pre", key_held, 1'b1);
    @(posedge clk);
    #1 chk("t5_held_fall", key_held, 1'b0);
    chk("t5_pulses", dut_pulses - p0, 1);
    wait_scans(1);

    // 6: reset mid-debounce, then clear during acceptance
    p0 = dut_pulses;
    pressed = kbit(4'h7);
    wait_scans(2);
    repeat (5) @(posedge clk);
    #1 pressed = 16'h0;
    do_reset();
    chk("t6_rst_held", key_held, 1'b0);
    chk("t6_rst_code", key_code, 4'h0);
    chk("t6_rst_col", col_sel, 4'b1110);
    chk("t6_nopulse", dut_pulses - p0, 0);
    for (int i = 0; i < 4; i++) tap(seq2[i], DB, DB);
    chk("t6_entry", entry, 16'h1234);
    pressed = kbit(4'h7);
    repeat (SCAN * DB - 1) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("t6_clr_valid", key_valid, 1'b1);
    chk("t6_clr_entry", entry, 16'h0007);
    pressed = 16'h0;
    wait_scans(4);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("t6_clear", entry, 16'h0);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
